// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, the $zero register index and the stage-control bundles.
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pcEn;
    logic ifIdEn;
    logic ifIdFlush;
    logic idExEn;
    logic idExFlush;
  } ctrl_t;

  localparam ctrl_t EN_ALL    = '{pcEn: 1'b1, ifIdEn: 1'b1, ifIdFlush: 1'b0, idExEn: 1'b1, idExFlush: 1'b0};
  // Hold PC and IF_ID, let ID_EX load a cleared slot: one bubble.
  localparam ctrl_t BUBBLE    = '{pcEn: 1'b0, ifIdEn: 1'b0, ifIdFlush: 1'b0, idExEn: 1'b1, idExFlush: 1'b1};
  localparam ctrl_t FLUSH_ALL = '{pcEn: 1'b1, ifIdEn: 1'b1, ifIdFlush: 1'b1, idExEn: 1'b1, idExFlush: 1'b1};
  localparam ctrl_t FREEZE    = '{pcEn: 1'b0, ifIdEn: 1'b0, ifIdFlush: 1'b0, idExEn: 1'b0, idExFlush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_rise_detect.sv
// Rising-edge detector for an already-synchronised level input (operator
// buttons); registers the level every cycle and pulses for one cycle on 0->1.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (!rst) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and syscall halt.
// Optional performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int COUNT_WIDTH    = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rt,
  input  logic                      ID_use_rs,
  input  logic                      ID_use_rt,
  input  logic                      EX_ramtoreg,
  input  logic                      EX_regwe,
  input  logic [REG_ADDR_WIDTH-1:0] EX_wreg,
  input  logic                      EX_redirect,
  input  logic                      EX_halt,
  input  logic                      go,
  output logic                      PC_en,
  output logic                      IF_ID_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_en,
  output logic                      ID_EX_flush,
  output logic                      halted,
  output logic [COUNT_WIDTH-1:0]    stall_cnt,
  output logic [COUNT_WIDTH-1:0]    flush_cnt
);

  import hazard_ctrl_pkg::*;

  localparam logic [REG_ADDR_WIDTH-1:0] WREG_ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  state_e state_q, state_d;
  logic   goPulse;
  logic   loadUse;
  ctrl_t  ctrl;

  rise_detect uGoRise (
    .clk   (clk),
    .rst   (rst),
    .din   (go),
    .pulse (goPulse)
  );

  assign loadUse = EX_ramtoreg & EX_regwe & (EX_wreg != WREG_ZERO) &
                   ((ID_use_rs & (ID_rs == EX_wreg)) | (ID_use_rt & (ID_rt == EX_wreg)));

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (EX_halt && !EX_redirect) state_d = ST_HALT;
    end else begin
      if (goPulse) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Reset forces the free-running bundle so the datapath clears cleanly.
  always_comb begin
    ctrl = EN_ALL;
    if (rst) begin
      if (state_q == ST_HALT) ctrl = FREEZE;
      else if (EX_redirect)   ctrl = FLUSH_ALL;
      else if (loadUse)       ctrl = BUBBLE;
    end
  end

  assign PC_en       = ctrl.pcEn;
  assign IF_ID_en    = ctrl.ifIdEn;
  assign IF_ID_flush = ctrl.ifIdFlush;
  assign ID_EX_en    = ctrl.idExEn;
  assign ID_EX_flush = ctrl.idExFlush;
  assign halted      = rst & (state_q == ST_HALT);

`ifdef HAZARD_CTRL_PERF_EN
  logic                   countFlush;
  logic                   countStall;
  logic [COUNT_WIDTH-1:0] stall_cnt_q;
  logic [COUNT_WIDTH-1:0] flush_cnt_q;

  assign countFlush = (state_q == ST_RUN) & EX_redirect;
  assign countStall = (state_q == ST_RUN) & ~EX_redirect & loadUse;

  // Counters wrap naturally at 2^COUNT_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (countStall) stall_cnt_q <= stall_cnt_q + COUNT_WIDTH'(1);
      if (countFlush) flush_cnt_q <= flush_cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed halt/reset/wrap
// sequences and a randomized run against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam int AW = 5;
`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ID_rs, ID_rt, EX_wreg;
  logic          ID_use_rs, ID_use_rt, EX_ramtoreg, EX_regwe;
  logic          EX_redirect, EX_halt, go;
  logic          PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.COUNT_WIDTH(CW), .REG_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ID_rs       (ID_rs),
    .ID_rt       (ID_rt),
    .ID_use_rs   (ID_use_rs),
    .ID_use_rt   (ID_use_rt),
    .EX_ramtoreg (EX_ramtoreg),
    .EX_regwe    (EX_regwe),
    .EX_wreg     (EX_wreg),
    .EX_redirect (EX_redirect),
    .EX_halt     (EX_halt),
    .go          (go),
    .PC_en       (PC_en),
    .IF_ID_en    (IF_ID_en),
    .IF_ID_flush (IF_ID_flush),
    .ID_EX_en    (ID_EX_en),
    .ID_EX_flush (ID_EX_flush),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // Control bundle order: {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush}
  localparam logic [4:0] C_EN  = 5'b11010;
  localparam logic [4:0] C_BUB = 5'b00011;
  localparam logic [4:0] C_FL  = 5'b11111;
  localparam logic [4:0] C_FRZ = 5'b00000;

  typedef struct {
    logic          ramtoreg;
    logic          regwe;
    logic [AW-1:0] wreg;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          useRs;
    logic          useRt;
    logic          redirect;
    logic [4:0]    expCtrl;
  } vec_t;

  int total = 0;
  int bad   = 0;

  bit mHalted = 1'b0;
  bit mGoPrev = 1'b0;
  int mStall  = 0;
  int mFlush  = 0;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic bit modelHazard();
    bit rsHit, rtHit;
    rsHit = ID_use_rs && (ID_rs == EX_wreg);
    rtHit = ID_use_rt && (ID_rt == EX_wreg);
    return EX_ramtoreg && EX_regwe && (EX_wreg != 0) && (rsHit || rtHit);
  endfunction

  function automatic logic [4:0] modelCtrl();
    if (!rst)          return C_EN;
    if (mHalted)       return C_FRZ;
    if (EX_redirect)   return C_FL;
    if (modelHazard()) return C_BUB;
    return C_EN;
  endfunction

  function automatic logic [CW-1:0] expCount(input int c);
    return PERF ? CW'(c % (1 << CW)) : '0;
  endfunction

  task automatic checkOutput(input string name);
    checkValue({name, ".ctrl"}, 32'({PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush}), 32'(modelCtrl()));
    checkValue({name, ".halted"}, 32'(halted), 32'(rst && mHalted));
    checkValue({name, ".stall_cnt"}, 32'(stall_cnt), 32'(expCount(mStall)));
    checkValue({name, ".flush_cnt"}, 32'(flush_cnt), 32'(expCount(mFlush)));
  endtask

  // Applies the rules of one clock edge using the inputs present at that edge.
  task automatic updateModel();
    if (!rst) begin
      mHalted = 1'b0;
      mGoPrev = 1'b0;
      mStall  = 0;
      mFlush  = 0;
    end else begin
      if (mHalted) begin
        if (go && !mGoPrev) mHalted = 1'b0;
      end else begin
        if (EX_redirect)        mFlush++;
        else if (modelHazard()) mStall++;
        if (EX_halt && !EX_redirect) mHalted = 1'b1;
      end
      mGoPrev = go;
    end
  endtask

  task automatic step(input string name);
    @(negedge clk);
    checkOutput(name);
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic clearInputs();
    rst = 1'b1;
    ID_rs = '0; ID_rt = '0; EX_wreg = '0;
    ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    EX_ramtoreg = 1'b0; EX_regwe = 1'b0;
    EX_redirect = 1'b0; EX_halt = 1'b0; go = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    EX_ramtoreg = v.ramtoreg;
    EX_regwe    = v.regwe;
    EX_wreg     = v.wreg;
    ID_rs       = v.rs;
    ID_rt       = v.rt;
    ID_use_rs   = v.useRs;
    ID_use_rt   = v.useRt;
    EX_redirect = v.redirect;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b0;
    step("reset");
    rst = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, C_BUB};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, C_EN};
    vecs[2] = '{1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, C_EN};
    vecs[3] = '{1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, C_EN};
    vecs[4] = '{1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, C_BUB};
    vecs[5] = '{1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, C_EN};
    vecs[6] = '{1'b1, 1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0, C_EN};
    vecs[7] = '{1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, C_FL};
    vecs[8] = '{1'b0, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, C_FL};
    vecs[9] = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, C_EN};

    clearInputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // Reset values once out of reset
    @(negedge clk);
    checkValue("resetHalted", 32'(halted), 32'd0);
    checkValue("resetStall", 32'(stall_cnt), 32'd0);
    checkValue("resetFlush", 32'(flush_cnt), 32'd0);
    checkValue("resetCtrl", 32'({PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush}), 32'(C_EN));
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkValue($sformatf("vec%0d.ctrl", i),
                 32'({PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush}), 32'(vecs[i].expCtrl));
      checkValue($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(expCount(mStall)));
      checkValue($sformatf("vec%0d.flush_cnt", i), 32'(flush_cnt), 32'(expCount(mFlush)));
      @(posedge clk);
      updateModel();
      #1;
    end

    // Load-use from clean counters: one bubble then stall_cnt 0->1
    doReset();
    applyStimulus(vecs[0]);
    step("luCycle");
    clearInputs();
    @(negedge clk);
    checkValue("luStallAfter", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    checkValue("luFlushAfter", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Halt with go already high, then a proper go rising edge
    clearInputs();
    EX_halt = 1'b1;
    go      = 1'b1;
    step("haltIssue");
    EX_halt = 1'b0;
    EX_redirect = 1'b1;
    step("haltFrozen1");
    checkValue("haltEntered", 32'(halted), 32'd1);
    checkValue("haltPcEn", 32'(PC_en), 32'd0);
    EX_redirect = 1'b0;
    step("haltGoHeld");
    go = 1'b0;
    step("haltGoLow1");
    step("haltGoLow2");
    go = 1'b1;
    step("haltGoRise");
    @(negedge clk);
    checkValue("resumeHalted", 32'(halted), 32'd0);
    checkValue("resumePcEn", 32'(PC_en), 32'd1);
    @(posedge clk);
    updateModel();
    #1;

    // Reset while halted
    clearInputs();
    EX_redirect = 1'b1;
    step("preHaltFlush");
    EX_redirect = 1'b0;
    EX_halt = 1'b1;
    step("midHaltIssue");
    EX_halt = 1'b0;
    step("midHaltFrozen");
    rst = 1'b0;
    step("midHaltReset");
    rst = 1'b1;
    @(negedge clk);
    checkValue("midResetHalted", 32'(halted), 32'd0);
    checkValue("midResetFlush", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    updateModel();
    #1;

    // Counter wrap at COUNT_WIDTH=4
    doReset();
    EX_redirect = 1'b1;
    for (int i = 0; i < 17; i++) step("wrapRedirect");
    @(negedge clk);
    checkValue("flushWrap", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    @(posedge clk);
    updateModel();
    #1;

    // Randomized run against the reference model
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 39) != 0);
      ID_rs       = AW'($urandom_range(0, 3));
      ID_rt       = AW'($urandom_range(0, 3));
      EX_wreg     = AW'($urandom_range(0, 3));
      ID_use_rs   = 1'($urandom_range(0, 1));
      ID_use_rt   = 1'($urandom_range(0, 1));
      EX_ramtoreg = 1'($urandom_range(0, 1));
      EX_regwe    = 1'($urandom_range(0, 1));
      EX_redirect = ($urandom_range(0, 5) == 0);
      EX_halt     = ($urandom_range(0, 11) == 0);
      go          = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
